// File: rtl/fnd_time_display.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_time_display
//  Function : Converts binary hh/mm/ss/cc fields into BCD and scans four
//             common-anode 7-segment digits. A debounced push-button toggles
//             between an HH.MM view and an SS.cc view.
//  Options  : FND_DP_BLINK_EN - when defined, the d2 decimal point blinks
//             at 1 Hz (lit while i_ms < 50); otherwise it is lit steadily.
//  Revision : 1.0 - initial release
// ============================================================================
module fnd_time_display #(
  parameter int SCAN_DIV     = 100_000,
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  input  logic [6:0] i_ms,
  input  logic       i_btn_mode,
  output logic [3:0] o_fnd_digit,
  output logic [7:0] o_fnd_font
);

  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [SC_W-1:0] SCAN_LAST = SC_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [7:0]      FONT_DASH = 8'hBF;

  typedef enum logic {
    MODE_HM = 1'b0,
    MODE_SC = 1'b1
  } mode_e;

  // Segment pattern for one decimal digit, dp off, active-low
  function automatic logic [7:0] seg_font(input logic [6:0] dig);
    logic [7:0] f;
    case (dig)
      7'd0:    f = 8'hC0;
      7'd1:    f = 8'hF9;
      7'd2:    f = 8'hA4;
      7'd3:    f = 8'hB0;
      7'd4:    f = 8'h99;
      7'd5:    f = 8'h92;
      7'd6:    f = 8'h82;
      7'd7:    f = 8'hF8;
      7'd8:    f = 8'h80;
      7'd9:    f = 8'h90;
      default: f = 8'hFF;
    endcase
    return f;
  endfunction

  logic              btn_meta_q, btn_sync_q;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              db_level_q, db_level_d;
  logic              db_prev_q;
  mode_e             mode_q, mode_d;
  logic [SC_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        fnd_digit_q, fnd_digit_d;
  logic [7:0]        fnd_font_q, fnd_font_d;

  logic [6:0]        hi_val, lo_val, sel_val, dig_val;
  logic              dp_on;

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      btn_meta_q <= i_btn_mode;
      btn_sync_q <= btn_meta_q;
    end
  end

  // Debounce: count consecutive samples that disagree with the accepted level
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Mode flips on each rising edge of the debounced level; release is ignored
  always_comb begin
    mode_d = mode_q;
    if (db_level_q && !db_prev_q) begin
      mode_d = (mode_q == MODE_HM) ? MODE_SC : MODE_HM;
    end
  end

  // Digit-slot timer and digit index
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  // Pick the field for the current digit, split into BCD and map to segments
  always_comb begin
    hi_val  = (mode_q == MODE_SC) ? {1'b0, i_sec} : {1'b0, i_hour};
    lo_val  = (mode_q == MODE_SC) ? i_ms          : {1'b0, i_min};
    sel_val = idx_q[1] ? hi_val : lo_val;
    dig_val = idx_q[0] ? (sel_val / 7'd10) : (sel_val % 7'd10);
`ifdef FND_DP_BLINK_EN
    dp_on   = (i_ms < 7'd50);
`else
    dp_on   = 1'b1;
`endif
    fnd_digit_d = ~(4'b0001 << idx_q);
    if (sel_val > 7'd99) begin
      fnd_font_d = FONT_DASH;
    end else begin
      fnd_font_d = seg_font(dig_val);
    end
    if ((idx_q == 2'd2) && dp_on) begin
      fnd_font_d[7] = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      db_cnt_q    <= '0;
      db_level_q  <= 1'b0;
      db_prev_q   <= 1'b0;
      mode_q      <= MODE_HM;
      scan_cnt_q  <= '0;
      idx_q       <= 2'd0;
      fnd_digit_q <= 4'b1111;
      fnd_font_q  <= 8'hFF;
    end else begin
      db_cnt_q    <= db_cnt_d;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_level_q;
      mode_q      <= mode_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      fnd_digit_q <= fnd_digit_d;
      fnd_font_q  <= fnd_font_d;
    end
  end

  assign o_fnd_digit = fnd_digit_q;
  assign o_fnd_font  = fnd_font_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_time_display.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnd_time_display
//  Function : Self-checking bench for fnd_time_display with a behavioural
//             display model plus literal expectations for key scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_time_display;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] hour = 6'd12, min = 6'd34, sec = 6'd7;
  logic [6:0] ms = 7'd89;
  logic       btn = 1'b0;
  logic [3:0] o_fnd_digit;
  logic [7:0] o_fnd_font;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  fnd_time_display #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_hour     (hour),
    .i_min      (min),
    .i_sec      (sec),
    .i_ms       (ms),
    .i_btn_mode (btn),
    .o_fnd_digit(o_fnd_digit),
    .o_fnd_font (o_fnd_font)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [7:0] FONT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [7:0] model_font(input int idx, input bit sc,
                                            input int h, input int m,
                                            input int s, input int c);
    int v;
    logic [7:0] f;
    bit dp;
    v = (idx >= 2) ? (sc ? s : h) : (sc ? c : m);
    if (v > 99) f = 8'hBF;
    else        f = FONT[(idx % 2 == 1) ? (v / 10) : (v % 10)];
`ifdef FND_DP_BLINK_EN
    dp = (c < 50);
`else
    dp = 1'b1;
`endif
    if (idx == 2 && dp) f[7] = 1'b0;
    return f;
  endfunction

  int         t;          // clock edges since reset release
  bit         m_mode;     // mode seen by the output stage
  bit         tog;        // toggle waiting to reach the mode register
  bit         lvl;        // accepted button level
  int         run;        // consecutive synchronized samples differing from lvl
  bit         hist [2];   // raw button at the last two edges (newest first)
  logic [3:0] exp_digit = 4'b1111;
  logic [7:0] exp_font  = 8'hFF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0; m_mode = 0; tog = 0; lvl = 0; run = 0;
      hist[0] = 0; hist[1] = 0;
      exp_digit = 4'b1111; exp_font = 8'hFF;
    end else begin
      int idx;
      bit samp;
      idx = (t / SD) % 4;
      exp_digit = 4'b1111;
      exp_digit[idx] = 1'b0;
      exp_font = model_font(idx, m_mode, int'(hour), int'(min), int'(sec), int'(ms));
      samp = hist[1];
      hist[1] = hist[0];
      hist[0] = btn;
      if (tog) m_mode = ~m_mode;
      tog = 0;
      if (samp != lvl) begin
        run++;
        if (run == DB) begin
          lvl = samp;
          run = 0;
          if (lvl) tog = 1;
        end
      end else begin
        run = 0;
      end
      t++;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (o_fnd_digit !== exp_digit || o_fnd_font !== exp_font) begin
        failures++;
        $display("FAIL model t=%0d: digit=%b font=%h expected digit=%b font=%h",
                 t, o_fnd_digit, o_fnd_font, exp_digit, exp_font);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit_now(input string nm, input logic [3:0] d, input logic [7:0] f);
    checks++;
    if (o_fnd_digit !== d || o_fnd_font !== f) begin
      failures++;
      $display("FAIL %s: got %b/%h expected %b/%h", nm, o_fnd_digit, o_fnd_font, d, f);
    end
  endtask

  // Wait (bounded) for digit d to be scanned, then check its font
  task automatic lit_wait(input string nm, input logic [3:0] d, input logic [7:0] f);
    int n = 0;
    @(negedge clk);
    while (o_fnd_digit !== d && n < 4 * SD + 4) begin
      @(negedge clk);
      n++;
    end
    lit_now(nm, d, f);
  endtask

  task automatic press(input int len);
    btn = 1'b1;
    cyc(len);
    btn = 1'b0;
    cyc(16);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] d2_ms50;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    cyc(3);
    lit_now("reset_blank", 4'b1111, 8'hFF);
    rst = 1'b0;

    // HH.MM = 12.34
    @(negedge clk);
    lit_now("first_d0", 4'b1110, 8'h99);
    lit_wait("hm_d1", 4'b1101, 8'hB0);
    lit_wait("hm_d2", 4'b1011, 8'h24);
    lit_wait("hm_d3", 4'b0111, 8'hF9);
    lit_wait("hm_d0_wrap", 4'b1110, 8'h99);

    // Stable press -> SS.cc = 07.89
    press(12);
    lit_wait("sc_d3", 4'b0111, 8'hC0);
`ifdef FND_DP_BLINK_EN
    lit_wait("sc_d2", 4'b1011, 8'hF8);
`else
    lit_wait("sc_d2", 4'b1011, 8'h78);
`endif
    lit_wait("sc_d1", 4'b1101, 8'h80);
    lit_wait("sc_d0", 4'b1110, 8'h90);

    // Second press returns to HH.MM
    press(12);
    lit_wait("back_hm_d0", 4'b1110, 8'h99);

    // Bounce every 3 cycles, then low: no toggle
    for (int i = 0; i < 40; i += 3) begin
      btn = ~btn;
      cyc(3);
    end
    btn = 1'b0;
    cyc(16);
    lit_wait("bounce_hm_d1", 4'b1101, 8'hB0);

    // Into SS.cc, ms out of range shows dashes
    press(12);
    ms = 7'd120;
    lit_wait("dash_d1", 4'b1101, 8'hBF);
    lit_wait("dash_d0", 4'b1110, 8'hBF);

    // Decimal point on d2
    ms = 7'd49;
    lit_wait("dp_ms49", 4'b1011, 8'h78);
    ms = 7'd50;
`ifdef FND_DP_BLINK_EN
    d2_ms50 = 8'hF8;
`else
    d2_ms50 = 8'h78;
`endif
    lit_wait("dp_ms50", 4'b1011, d2_ms50);

    // Reset in the middle of a slot while in SS.cc
    lit_wait("pre_reset_d2", 4'b1011, d2_ms50);
    #2 rst = 1'b1;
    #1 lit_now("midslot_reset", 4'b1111, 8'hFF);
    cyc(2);
    rst = 1'b0;
    @(negedge clk);
    lit_now("restart_hm_d0", 4'b1110, 8'h99);

    // Randomized phase, checked every cycle by the model
    for (int i = 0; i < 200; i++) begin
      hour = 6'($urandom_range(0, 63));
      min  = 6'($urandom_range(0, 63));
      sec  = 6'($urandom_range(0, 63));
      ms   = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 2) == 0) btn = ~btn;
      cyc($urandom_range(1, 14));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
